// File: rtl/map_latch_gen.sv
// Discrete-latch PRG/CHR bank mapper with an optional speech-sample trigger sequencer.
// Define MAP_SPEECH_EN to build the sequencer, its CPU window, readback and save-state slot 2.
module map_latch_gen #(
   parameter int unsigned PRG_BITS  = 2,
   parameter int unsigned CHR_BITS  = 3,
   parameter logic [3:0]  REG_NIB   = 4'h6,
   parameter logic [3:0]  SPK_NIB   = 4'h7,
   parameter int unsigned START_CYC = 4,
   parameter int unsigned PLAY_CYC  = 4096
) (
   input  logic                m2,
   input  logic                map_rst_n,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_data,
   input  logic                cpu_rw,
   input  logic [13:0]         ppu_addr,
   input  logic                cfg_mir_v,
   input  logic [7:0]          cfg_map_idx,
   input  logic                sst_act,
   input  logic                sst_we_reg,
   input  logic [7:0]          sst_addr,
   input  logic [7:0]          sst_dato,
   output logic [7:0]          sst_di,
   output logic [PRG_BITS-1:0] prg_bank,
   output logic [CHR_BITS-1:0] chr_bank,
   output logic                ciram_a10,
   output logic                ciram_ce,
   output logic                cpu_oe,
   output logic [7:0]          cpu_do,
   output logic                spk_start,
   output logic [3:0]          spk_id,
   output logic                spk_irq
);

   // ------------------------------------------------------------------
   // Bus decode shared by the latch and the sequencer
   // ------------------------------------------------------------------
   logic cpu_wr;
   logic reg_sel;
   logic sst_wr0;
   logic sst_wr1;
   logic sst_wr2;

   assign cpu_wr  = !cpu_rw && !sst_act;
   assign reg_sel = (cpu_addr[15:12] == REG_NIB);
   assign sst_wr0 = sst_we_reg && (sst_addr == 8'd0);
   assign sst_wr1 = sst_we_reg && (sst_addr == 8'd1);
   assign sst_wr2 = sst_we_reg && (sst_addr == 8'd2);

   // Full-width bank fields scattered across the data byte; upper bits drop when narrower.
   logic [2:0] prg_full;
   logic [4:0] chr_full;

   assign prg_full = {cpu_data[7], cpu_data[5:4]};
   assign chr_full = {cpu_data[3], cpu_data[2], cpu_data[6], cpu_data[1:0]};

   // ------------------------------------------------------------------
   // Bank latch
   // ------------------------------------------------------------------
   logic [PRG_BITS-1:0] prg_q, prg_d;
   logic [CHR_BITS-1:0] chr_q, chr_d;

   // NOTE: every combinational output gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      prg_d = prg_q;
      chr_d = chr_q;
      if (cpu_wr && reg_sel) begin
         prg_d = prg_full[PRG_BITS-1:0];
         chr_d = chr_full[CHR_BITS-1:0];
      end
      if (sst_wr0) prg_d = sst_dato[PRG_BITS-1:0];
      if (sst_wr1) chr_d = sst_dato[CHR_BITS-1:0];
   end

   // NOTE: state registers use non-blocking assignments; all state advances on the falling edge of m2.
   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         prg_q <= '0;
         chr_q <= '0;
      end else begin
         prg_q <= prg_d;
         chr_q <= chr_d;
      end
   end

   assign prg_bank  = prg_q;
   assign chr_bank  = chr_q;
   assign ciram_a10 = cfg_mir_v ? ppu_addr[10] : ppu_addr[11];
   assign ciram_ce  = !ppu_addr[13];

   logic [7:0] sst_spk;

`ifdef MAP_SPEECH_EN
   // ------------------------------------------------------------------
   // Speech trigger sequencer
   // ------------------------------------------------------------------
   localparam int unsigned MAX_CYC = (START_CYC > PLAY_CYC) ? START_CYC : PLAY_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
   localparam logic [CNT_W-1:0] PLAY_LAST  = CNT_W'(PLAY_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } spk_state_e;

   spk_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       id_q, id_d;
   logic             irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic             spk_sel;
   logic             spk_wr;
   logic             busy;

   assign spk_sel = (cpu_addr[15:12] == SPK_NIB);
   assign spk_wr  = cpu_wr && spk_sel;
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      irq_en_d = irq_en_q;
      irq_d    = irq_q;

      case (state_q)
         ST_START: begin
            if (cnt_q == START_LAST) begin
               state_d = ST_BUSY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_BUSY: begin
            if (cnt_q == PLAY_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (irq_en_q) irq_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: ;
      endcase

      // A CPU write overrides the sequencing above, including a completion on the same edge.
      if (spk_wr) begin
         irq_d = 1'b0;
         if (!cpu_data[4]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else if (state_q == ST_IDLE) begin
            state_d  = ST_START;
            cnt_d    = '0;
            id_d     = cpu_data[3:0];
            irq_en_d = cpu_data[5];
         end
      end

      if (sst_wr2) begin
         irq_en_d = sst_dato[7];
         irq_d    = sst_dato[6];
         state_d  = (sst_dato[5:4] == 2'd3) ? ST_IDLE : spk_state_e'(sst_dato[5:4]);
         cnt_d    = '0;
         id_d     = sst_dato[3:0];
      end
   end

   always_ff @(negedge m2 or negedge map_rst_n) begin
      if (!map_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         id_q     <= 4'h0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign spk_start = (state_q == ST_START);
   assign spk_id    = id_q;
   assign spk_irq   = irq_q;
   assign cpu_oe    = cpu_rw && spk_sel;
   assign cpu_do    = cpu_oe ? {1'b0, busy, irq_q, 1'b0, id_q} : 8'h00;
   assign sst_spk   = {irq_en_q, irq_q, state_q, id_q};
`else
   logic unused_cfg;

   assign spk_start  = 1'b0;
   assign spk_id     = 4'h0;
   assign spk_irq    = 1'b0;
   assign cpu_oe     = 1'b0;
   assign cpu_do     = 8'h00;
   assign sst_spk    = 8'hFF;
   assign unused_cfg = ^{SPK_NIB, 32'(START_CYC), 32'(PLAY_CYC), sst_wr2};
`endif

   // ------------------------------------------------------------------
   // Save-state readback
   // ------------------------------------------------------------------
   always_comb begin
      sst_di = 8'hFF;
      case (sst_addr)
         8'd0:    sst_di = 8'(prg_q);
         8'd1:    sst_di = 8'(chr_q);
         8'd2:    sst_di = sst_spk;
         8'd127:  sst_di = cfg_map_idx;
         default: sst_di = 8'hFF;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{cpu_addr, cpu_data, ppu_addr, sst_dato, prg_full, chr_full};

endmodule

// File: tb/tb_map_latch_gen.sv
// Randomized scoreboard bench for map_latch_gen; a timeline-based reference model predicts every cycle.
// Directed sequences cover the latch, speech timing, retrigger/abort, async reset and save-state paths.
module tb_map_latch_gen;

   localparam int PRG_BITS  = 3;
   localparam int CHR_BITS  = 5;
   localparam int START_CYC = 4;
   localparam int PLAY_CYC  = 16;
   localparam logic [3:0] REG_NIB = 4'h6;
   localparam logic [3:0] SPK_NIB = 4'h7;
   localparam logic [7:0] MAP_IDX = 8'h5C;
`ifdef MAP_SPEECH_EN
   localparam bit         SPEECH   = 1'b1;
   localparam logic [7:0] SST2_EXP = 8'h6A;
`else
   localparam bit         SPEECH   = 1'b0;
   localparam logic [7:0] SST2_EXP = 8'hFF;
`endif

   logic                m2, map_rst_n;
   logic [15:0]         cpu_addr;
   logic [7:0]          cpu_data;
   logic                cpu_rw;
   logic [13:0]         ppu_addr;
   logic                cfg_mir_v;
   logic [7:0]          cfg_map_idx;
   logic                sst_act, sst_we_reg;
   logic [7:0]          sst_addr, sst_dato, sst_di;
   logic [PRG_BITS-1:0] prg_bank;
   logic [CHR_BITS-1:0] chr_bank;
   logic                ciram_a10, ciram_ce, cpu_oe;
   logic [7:0]          cpu_do;
   logic                spk_start, spk_irq;
   logic [3:0]          spk_id;

   map_latch_gen #(
      .PRG_BITS(PRG_BITS), .CHR_BITS(CHR_BITS), .REG_NIB(REG_NIB), .SPK_NIB(SPK_NIB),
      .START_CYC(START_CYC), .PLAY_CYC(PLAY_CYC)
   ) dut (
      .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v), .cfg_map_idx(cfg_map_idx),
      .sst_act(sst_act), .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
      .sst_di(sst_di), .prg_bank(prg_bank), .chr_bank(chr_bank), .ciram_a10(ciram_a10),
      .ciram_ce(ciram_ce), .cpu_oe(cpu_oe), .cpu_do(cpu_do), .spk_start(spk_start),
      .spk_id(spk_id), .spk_irq(spk_irq)
   );

   initial m2 = 1'b0;
   always #5 m2 = ~m2;

   typedef struct {
      bit          rst_n;
      logic [15:0] addr;
      logic [7:0]  data;
      bit          rw;
      logic [13:0] pa;
      bit          mir;
      bit          act;
      bit          we;
      logic [7:0]  sa;
      logic [7:0]  sd;
   } stim_t;

   typedef struct {
      logic [PRG_BITS-1:0] prg;
      logic [CHR_BITS-1:0] chr;
      logic                a10, ce, oe, start, irq;
      logic [7:0]          dout, sdi;
      logic [3:0]          id;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Reference model: a sample is a timeline starting at m_t0; phase follows from elapsed edges.
   int m_prg, m_chr, m_cyc, m_t0, m_id;
   bit m_active, m_irq_en, m_irq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_prg = 0; m_chr = 0; m_active = 0; m_irq_en = 0; m_irq = 0; m_id = 0; m_t0 = 0;
   endtask

   task automatic apply(input stim_t s);
      exp_t e;
      int   d, el, st;
      bit   was_active;
      map_rst_n = s.rst_n; cpu_addr = s.addr; cpu_data = s.data; cpu_rw = s.rw;
      ppu_addr = s.pa; cfg_mir_v = s.mir; sst_act = s.act; sst_we_reg = s.we;
      sst_addr = s.sa; sst_dato = s.sd;
      m_cyc++;
      d = s.data;
      if (!s.rst_n) begin
         model_reset();
      end else begin
         was_active = m_active;
         if (m_active && (m_cyc - m_t0 == START_CYC + PLAY_CYC)) begin
            m_active = 0;
            if (m_irq_en) m_irq = 1;
         end
         if (!s.rw && !s.act && s.addr[15:12] == REG_NIB) begin
            m_prg = (((d >> 4) & 3) | (((d >> 7) & 1) << 2)) % (1 << PRG_BITS);
            m_chr = ((d & 3) | (((d >> 6) & 1) << 2) | (((d >> 2) & 1) << 3) |
                     (((d >> 3) & 1) << 4)) % (1 << CHR_BITS);
         end
         if (SPEECH && !s.rw && !s.act && s.addr[15:12] == SPK_NIB) begin
            m_irq = 0;
            if (((d >> 4) & 1) == 0) m_active = 0;
            else if (!was_active) begin
               m_active = 1; m_t0 = m_cyc; m_id = d & 15; m_irq_en = (d >> 5) & 1;
            end
         end
         if (s.we) begin
            if (s.sa == 8'd0) m_prg = s.sd % (1 << PRG_BITS);
            if (s.sa == 8'd1) m_chr = s.sd % (1 << CHR_BITS);
            if (s.sa == 8'd2 && SPEECH) begin
               m_irq_en = s.sd[7]; m_irq = s.sd[6]; m_id = s.sd[3:0]; st = s.sd[5:4];
               m_active = (st == 1) || (st == 2);
               m_t0     = (st == 2) ? m_cyc - START_CYC : m_cyc;
            end
         end
      end
      el    = m_cyc - m_t0;
      st    = !m_active ? 0 : (el < START_CYC ? 1 : 2);
      e.prg = PRG_BITS'(m_prg);
      e.chr = CHR_BITS'(m_chr);
      e.a10 = s.mir ? s.pa[10] : s.pa[11];
      e.ce  = !s.pa[13];
      e.start = SPEECH && m_active && (el < START_CYC);
      e.id    = SPEECH ? 4'(m_id) : 4'h0;
      e.irq   = SPEECH && m_irq;
      e.oe    = SPEECH && s.rw && (s.addr[15:12] == SPK_NIB);
      e.dout  = e.oe ? {1'b0, m_active, m_irq, 1'b0, 4'(m_id)} : 8'h00;
      case (s.sa)
         8'd0:    e.sdi = 8'(m_prg);
         8'd1:    e.sdi = 8'(m_chr);
         8'd2:    e.sdi = SPEECH ? {m_irq_en, m_irq, 2'(st), 4'(m_id)} : 8'hFF;
         8'd127:  e.sdi = MAP_IDX;
         default: e.sdi = 8'hFF;
      endcase
      sb_q.push_back(e);
   endtask

   // Monitor: one expected snapshot per m2 cycle, compared just after the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge m2);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("prg_bank",  prg_bank,  e.prg);
            check("chr_bank",  chr_bank,  e.chr);
            check("ciram_a10", ciram_a10, e.a10);
            check("ciram_ce",  ciram_ce,  e.ce);
            check("cpu_oe",    cpu_oe,    e.oe);
            check("cpu_do",    cpu_do,    e.dout);
            check("spk_start", spk_start, e.start);
            check("spk_id",    spk_id,    e.id);
            check("spk_irq",   spk_irq,   e.irq);
            check("sst_di",    sst_di,    e.sdi);
         end
      end
   end

   function automatic stim_t idle_s();
      stim_t s;
      s.rst_n = 1; s.addr = 16'h8000; s.data = 8'h00; s.rw = 1;
      s.pa = 14'($urandom); s.mir = 1'($urandom);
      s.act = 0; s.we = 0; s.sa = 8'd200; s.sd = 8'h00;
      return s;
   endfunction

   function automatic stim_t wr_s(input logic [15:0] a, input logic [7:0] d);
      stim_t s = idle_s();
      s.addr = a; s.data = d; s.rw = 0;
      return s;
   endfunction

   function automatic stim_t rd_s(input logic [15:0] a);
      stim_t s = idle_s();
      s.addr = a;
      return s;
   endfunction

   function automatic stim_t sst_s(input logic [7:0] idx, input bit we, input logic [7:0] d);
      stim_t s = idle_s();
      s.act = 1; s.we = we; s.sa = idx; s.sd = d;
      return s;
   endfunction

   task automatic cyc(input stim_t s);
      @(posedge m2);
      apply(s);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(idle_s());
   endtask

   task automatic settle();
      @(negedge m2);
      #2;
   endtask

   function automatic stim_t rand_s();
      stim_t s = idle_s();
      int    r = $urandom_range(0, 99);
      s.addr = 16'($urandom);
      if (r < 8) s = wr_s({REG_NIB, 12'($urandom)}, 8'($urandom));
      else if (r < 14) begin
         s = wr_s({SPK_NIB, 12'($urandom)}, 8'($urandom));
         if ($urandom_range(0, 9) < 7) s.data[4] = 1'b1;
      end
      else if (r < 30) s = rd_s({SPK_NIB, 12'($urandom)});
      else if (r < 40) s = wr_s(16'($urandom), 8'($urandom));
      else if (r < 52) s = sst_s(($urandom_range(0, 4) == 4) ? 8'd127 : 8'($urandom_range(0, 5)), 0, 8'h00);
      else if (r < 55) s = sst_s(8'($urandom_range(0, 2)), 1, 8'($urandom));
      else if (r < 58) begin
         s = wr_s({REG_NIB, 12'($urandom)}, 8'($urandom));
         s.act = 1;
      end
      else if (r == 99) s.rst_n = 0;
      return s;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      stim_t s;
      m_cyc = 0;
      model_reset();
      cfg_map_idx = MAP_IDX;
      map_rst_n = 1; cpu_addr = 16'h8000; cpu_data = 8'h00; cpu_rw = 1; ppu_addr = '0;
      cfg_mir_v = 0; sst_act = 0; sst_we_reg = 0; sst_addr = 8'd200; sst_dato = 8'h00;
      #1 map_rst_n = 0;
      #1;
      check("rst_prg",   prg_bank,  0);
      check("rst_chr",   chr_bank,  0);
      check("rst_start", spk_start, 0);
      check("rst_irq",   spk_irq,   0);
      check("rst_oe",    cpu_oe,    0);
      s = idle_s(); s.rst_n = 0;
      cyc(s); cyc(s);
      idle_n(1);

      cyc(wr_s(16'h6000, 8'hF3)); settle();
      check("latch_prg", prg_bank, 3'b111);
      check("latch_chr", chr_bank, 5'b00111);

`ifdef MAP_SPEECH_EN
      cyc(wr_s(16'h7000, 8'h3A)); settle();                 // edge 0
      check("trig_start", spk_start, 1);
      check("trig_id",    spk_id,    4'hA);
      cyc(rd_s(16'h7000)); settle();                        // edge 1
      check("rd_busy", cpu_do, 8'h4A);
      check("rd_oe",   cpu_oe, 1);
      idle_n(2); settle();                                  // edge 3
      check("start_last", spk_start, 1);
      idle_n(1); settle();                                  // edge 4
      check("start_fall", spk_start, 0);
      idle_n(14);
      cyc(rd_s(16'h7000)); settle();                        // edge 19
      check("busy_end", cpu_do, 8'h4A);
      check("irq_early", spk_irq, 0);
      idle_n(1); settle();                                  // edge 20
      check("irq_set", spk_irq, 1);
      cyc(rd_s(16'h7000)); settle();
      check("rd_irq", cpu_do, 8'h2A);
      cyc(wr_s(16'h7000, 8'h00)); settle();
      check("irq_clr", spk_irq, 0);

      cyc(wr_s(16'h7000, 8'h3A)); idle_n(7);
      cyc(wr_s(16'h7000, 8'h15)); settle();                 // edge 8, ignored
      check("retrig_id", spk_id, 4'hA);
      idle_n(10);
      cyc(rd_s(16'h7000)); settle();                        // edge 19
      check("retrig_busy", cpu_do, 8'h4A);
      idle_n(1); settle();                                  // edge 20
      check("retrig_irq", spk_irq, 1);
      cyc(wr_s(16'h7000, 8'h00));

      cyc(wr_s(16'h7000, 8'h3A)); idle_n(9);
      cyc(wr_s(16'h7000, 8'h00)); settle();
      cyc(rd_s(16'h7000)); settle();
      check("abort_idle", cpu_do, 8'h0A);
      idle_n(15); settle();
      check("abort_noirq", spk_irq, 0);

      cyc(wr_s(16'h7000, 8'h3A));
`else
      cyc(wr_s(16'h7000, 8'h1A)); settle();
      check("nospk_start", spk_start, 0);
      cyc(rd_s(16'h7000)); settle();
      check("nospk_oe", cpu_oe, 0);
      check("nospk_do", cpu_do, 8'h00);
      check("nospk_bank", prg_bank, 3'b111);
`endif
      @(posedge m2);
      #2 map_rst_n = 0;
      #1;
      check("arst_prg",   prg_bank,  0);
      check("arst_chr",   chr_bank,  0);
      check("arst_start", spk_start, 0);
      check("arst_id",    spk_id,    0);
      check("arst_irq",   spk_irq,   0);
      s = idle_s(); s.rst_n = 0;
      apply(s);
      idle_n(1);
      cyc(rd_s(16'h7000)); settle();
      check("arst_do", cpu_do, 8'h00);

      cyc(wr_s(16'h6000, 8'hF3));
      cyc(sst_s(8'd2, 1, 8'h6A));
      cyc(sst_s(8'd0, 0, 8'h00)); settle();
      check("sst_rd0", sst_di, 8'h07);
      cyc(sst_s(8'd1, 0, 8'h00)); settle();
      check("sst_rd1", sst_di, 8'h07);
      cyc(sst_s(8'd2, 0, 8'h00)); settle();
      check("sst_rd2", sst_di, SST2_EXP);
      check("sst_irq", spk_irq, SPEECH);
      cyc(sst_s(8'd127, 0, 8'h00)); settle();
      check("sst_rd127", sst_di, MAP_IDX);
      cyc(sst_s(8'd5, 0, 8'h00)); settle();
      check("sst_rd5", sst_di, 8'hFF);
      s = wr_s(16'h6000, 8'h00); s.act = 1;
      cyc(s); settle();
      check("sst_lock_prg", prg_bank, 3'b111);
      check("sst_lock_chr", chr_bank, 5'b00111);
      cyc(sst_s(8'd0, 1, 8'hFD));
      cyc(sst_s(8'd1, 1, 8'hE9)); settle();
      check("sst_wr_prg", prg_bank, 3'b101);
      check("sst_wr_chr", chr_bank, 5'b01001);
      cyc(wr_s(16'h7000, 8'h00));

      for (int i = 0; i < 1500; i++) cyc(rand_s());
      idle_n(2);
      repeat (4) @(negedge m2);
      #3;
      check("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
